// File: rtl/qsfp_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : qsfp_link_monitor
// Description : Synchronizes Aurora QSFP status, debounces channel_up into a
//               DOWN/QUAL/UP link state, and keeps error and drop counters.
// Revision    : 1.0
// ============================================================================
module qsfp_link_monitor #(
  parameter int LANE_COUNT      = 4,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  raw_channel_up,
  input  logic [LANE_COUNT-1:0] raw_lane_up,
  input  logic                  raw_gt_pll_lock,
  input  logic                  raw_hard_err,
  input  logic                  raw_soft_err,
  input  logic                  raw_mmcm_not_locked_out,
  input  logic                  clear,
  output logic                  link_up,
  output logic [1:0]            link_state,
  output logic [LANE_COUNT-1:0] lane_up,
  output logic                  gt_pll_lock,
  output logic                  mmcm_not_locked_out,
  output logic                  hard_err_sticky,
  output logic [CNT_WIDTH-1:0]  soft_err_count,
  output logic [CNT_WIDTH-1:0]  link_drop_count,
  output logic [31:0]           status_word
);

  localparam int SYNC_W = LANE_COUNT + 5;
  localparam int QUAL_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [QUAL_W-1:0]    QUAL_LAST = QUAL_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [QUAL_W-1:0]    QUAL_ONE  = QUAL_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_DOWN = 2'd0;
  localparam logic [1:0] ST_QUAL = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;

  logic [SYNC_W-1:0] raw_bus;
  logic [SYNC_W-1:0] sync_meta;
  logic [SYNC_W-1:0] sync_out;

  logic                  s_mmcm_not_locked_out;
  logic                  s_soft_err;
  logic                  s_hard_err;
  logic                  s_gt_pll_lock;
  logic                  s_channel_up;
  logic [LANE_COUNT-1:0] s_lane_up;
  logic                  soft_err_d;
  logic                  soft_err_rise;
  logic                  clocks_ok;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [QUAL_W-1:0] qual_cnt;
  logic [QUAL_W-1:0] qual_cnt_next;
  logic              drop_event;

  assign raw_bus = {raw_lane_up, raw_channel_up, raw_gt_pll_lock,
                    raw_hard_err, raw_soft_err, raw_mmcm_not_locked_out};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_meta  <= '0;
      sync_out   <= '0;
      soft_err_d <= 1'b0;
    end else begin
      sync_meta  <= raw_bus;
      sync_out   <= sync_meta;
      soft_err_d <= s_soft_err;
    end
  end

  assign s_mmcm_not_locked_out = sync_out[0];
  assign s_soft_err            = sync_out[1];
  assign s_hard_err            = sync_out[2];
  assign s_gt_pll_lock         = sync_out[3];
  assign s_channel_up          = sync_out[4];
  assign s_lane_up             = sync_out[SYNC_W-1:5];

  assign soft_err_rise = s_soft_err & ~soft_err_d;
  assign clocks_ok     = s_gt_pll_lock & ~s_mmcm_not_locked_out;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_DOWN;
      qual_cnt <= '0;
    end else begin
      state    <= state_next;
      qual_cnt <= qual_cnt_next;
    end
  end

  // Lost clocking overrides channel_up in every state.
  always_comb begin
    state_next    = state;
    qual_cnt_next = qual_cnt;
    case (state)
      ST_DOWN: begin
        qual_cnt_next = '0;
        if (clocks_ok && s_channel_up) begin
          state_next    = ST_QUAL;
          qual_cnt_next = QUAL_ONE;
        end
      end
      ST_QUAL: begin
        if (!clocks_ok || !s_channel_up) begin
          state_next    = ST_DOWN;
          qual_cnt_next = '0;
        end else if (qual_cnt == QUAL_LAST) begin
          state_next    = ST_UP;
          qual_cnt_next = '0;
        end else begin
          qual_cnt_next = qual_cnt + QUAL_ONE;
        end
      end
      ST_UP: begin
        qual_cnt_next = '0;
        if (!clocks_ok || !s_channel_up) state_next = ST_DOWN;
      end
      default: begin
        state_next    = ST_DOWN;
        qual_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    link_state = state;
    link_up    = (state == ST_UP);
    drop_event = (state == ST_UP) && (state_next != ST_UP);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      soft_err_count  <= '0;
      link_drop_count <= '0;
      hard_err_sticky <= 1'b0;
    end else begin
      if (clear)
        soft_err_count <= '0;
      else if (soft_err_rise && soft_err_count != CNT_MAX)
        soft_err_count <= soft_err_count + 1'b1;

      if (clear)
        link_drop_count <= '0;
      else if (drop_event && link_drop_count != CNT_MAX)
        link_drop_count <= link_drop_count + 1'b1;

      // A live hard error outranks clear.
      if (s_hard_err)
        hard_err_sticky <= 1'b1;
      else if (clear)
        hard_err_sticky <= 1'b0;
    end
  end

  assign lane_up             = s_lane_up;
  assign gt_pll_lock         = s_gt_pll_lock;
  assign mmcm_not_locked_out = s_mmcm_not_locked_out;

  always_comb begin
    status_word                   = '0;
    status_word[LANE_COUNT-1:0]   = s_lane_up;
    status_word[4]                = link_up;
    status_word[5]                = s_gt_pll_lock;
    status_word[6]                = hard_err_sticky;
    status_word[7]                = s_mmcm_not_locked_out;
    status_word[8]                = (soft_err_count != '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_qsfp_link_monitor.sv
`default_nettype none
// Bench for qsfp_link_monitor: directed scenarios plus randomized traffic,
// checked every cycle against a run-length model of link qualification.
module tb_qsfp_link_monitor;

  localparam int LN  = 4;
  localparam int DEB = 16;
  localparam int CW  = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          raw_channel_up = 1'b0;
  logic [LN-1:0] raw_lane_up = '0;
  logic          raw_gt_pll_lock = 1'b0;
  logic          raw_hard_err = 1'b0;
  logic          raw_soft_err = 1'b0;
  logic          raw_mmcm_not_locked_out = 1'b0;
  logic          clear = 1'b0;

  logic          link_up;
  logic [1:0]    link_state;
  logic [LN-1:0] lane_up;
  logic          gt_pll_lock;
  logic          mmcm_not_locked_out;
  logic          hard_err_sticky;
  logic [CW-1:0] soft_err_count;
  logic [CW-1:0] link_drop_count;
  logic [31:0]   status_word;

  int checks = 0;
  int failures = 0;

  qsfp_link_monitor #(.LANE_COUNT(LN), .DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .raw_channel_up(raw_channel_up), .raw_lane_up(raw_lane_up),
    .raw_gt_pll_lock(raw_gt_pll_lock), .raw_hard_err(raw_hard_err),
    .raw_soft_err(raw_soft_err), .raw_mmcm_not_locked_out(raw_mmcm_not_locked_out),
    .clear(clear), .link_up(link_up), .link_state(link_state),
    .lane_up(lane_up), .gt_pll_lock(gt_pll_lock),
    .mmcm_not_locked_out(mmcm_not_locked_out), .hard_err_sticky(hard_err_sticky),
    .soft_err_count(soft_err_count), .link_drop_count(link_drop_count),
    .status_word(status_word)
  );

  always #5 clk = ~clk;

  // Model: two-stage delay of raw samples, then link state derived purely
  // from the length of the current run of "good" synchronized cycles.
  logic [LN+4:0] m_stage1 = '0, m_stage2 = '0;
  logic          m_soft_prev = 1'b0;
  int            m_run = 0;
  int            m_soft = 0;
  int            m_drop = 0;
  logic          m_sticky = 1'b0;

  function automatic logic [LN+4:0] raw_pack();
    return {raw_lane_up, raw_channel_up, raw_gt_pll_lock,
            raw_hard_err, raw_soft_err, raw_mmcm_not_locked_out};
  endfunction

  task automatic model_update();
    logic good, rise, was_up;
    if (!resetn) begin
      m_stage1 = '0; m_stage2 = '0; m_soft_prev = 1'b0;
      m_run = 0; m_soft = 0; m_drop = 0; m_sticky = 1'b0;
    end else begin
      good   = m_stage2[4] && m_stage2[3] && !m_stage2[0];
      rise   = m_stage2[1] && !m_soft_prev;
      was_up = (m_run >= DEB);
      m_run  = good ? ((m_run >= DEB) ? DEB : m_run + 1) : 0;
      if (clear) m_drop = 0;
      else if (was_up && m_run == 0 && m_drop < CMAX) m_drop++;
      if (clear) m_soft = 0;
      else if (rise && m_soft < CMAX) m_soft++;
      if (m_stage2[2]) m_sticky = 1'b1;
      else if (clear) m_sticky = 1'b0;
      m_soft_prev = m_stage2[1];
      m_stage2    = m_stage1;
      m_stage1    = raw_pack();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [1:0]  exp_state;
    logic        exp_up;
    logic [31:0] exp_sw;
    exp_state = (m_run == 0) ? 2'd0 : (m_run < DEB) ? 2'd1 : 2'd2;
    exp_up    = (exp_state == 2'd2);
    exp_sw    = {23'b0, (m_soft != 0), m_stage2[0], m_sticky, m_stage2[3], exp_up, m_stage2[LN+4:5]};
    chk("link_state", link_state, exp_state);
    chk("link_up", link_up, exp_up);
    chk("lane_up", lane_up, m_stage2[LN+4:5]);
    chk("gt_pll_lock", gt_pll_lock, m_stage2[3]);
    chk("mmcm", mmcm_not_locked_out, m_stage2[0]);
    chk("hard_err_sticky", hard_err_sticky, m_sticky);
    chk("soft_err_count", soft_err_count, m_soft);
    chk("link_drop_count", link_drop_count, m_drop);
    chk("status_word", status_word, exp_sw);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // Reset and basic qualification timing.
    resetn = 1'b0;
    steps(2);
    chk("reset_state", link_state, 2'd0);
    chk("reset_status", status_word, 32'd0);
    resetn = 1'b1;
    raw_channel_up = 1'b1; raw_gt_pll_lock = 1'b1; raw_lane_up = 4'hF;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 1)  chk("state_edge1", link_state, 2'd0);
      if (i == 2)  chk("state_edge2", link_state, 2'd1);
      if (i == 16) chk("up_edge16", link_up, 1'b0);
      if (i == 17) chk("up_edge17", link_up, 1'b1);
    end
    chk("no_drop_initial", link_drop_count, 0);

    // Channel drops in UP: link_up falls two edges later.
    raw_channel_up = 1'b0;
    step();
    chk("drop_edge0", link_up, 1'b1);
    step(); step();
    chk("drop_edge2", link_up, 1'b0);
    chk("drop_count1", link_drop_count, 1);

    // Glitch during qualification restarts the window.
    raw_channel_up = 1'b1; steps(10);
    raw_channel_up = 1'b0; steps(1);
    raw_channel_up = 1'b1; steps(14);
    chk("glitch_not_up", link_up, 1'b0);
    steps(10);
    chk("glitch_up_later", link_up, 1'b1);
    chk("glitch_no_drop", link_drop_count, 1);

    // PLL lock loss in UP counts a drop.
    raw_gt_pll_lock = 1'b0; steps(3);
    chk("pll_drop", link_up, 1'b0);
    chk("pll_drop_count", link_drop_count, 2);
    raw_gt_pll_lock = 1'b1; steps(20);

    // Soft error saturation and level behaviour.
    for (int i = 0; i < 20; i++) begin
      raw_soft_err = 1'b1; step();
      raw_soft_err = 1'b0; step();
    end
    steps(3);
    chk("soft_sat", soft_err_count, 15);
    clear = 1'b1; step(); clear = 1'b0; step();
    raw_soft_err = 1'b1; steps(5); raw_soft_err = 1'b0; steps(4);
    chk("soft_level_once", soft_err_count, 1);

    // Clear coincident with a soft error increment edge.
    raw_soft_err = 1'b1; step();
    raw_soft_err = 1'b0; step();
    clear = 1'b1; step(); clear = 1'b0; step();
    chk("clear_wins_soft", soft_err_count, 0);

    // Hard error sticky vs clear.
    raw_hard_err = 1'b1; step(); raw_hard_err = 1'b0; steps(3);
    chk("hard_set", hard_err_sticky, 1'b1);
    clear = 1'b1; step(); clear = 1'b0; step();
    chk("hard_cleared", hard_err_sticky, 1'b0);
    raw_hard_err = 1'b1; steps(2);
    clear = 1'b1; step(); clear = 1'b0;
    raw_hard_err = 1'b0; step();
    chk("hard_set_wins", hard_err_sticky, 1'b1);

    // Single-cycle reset while UP with non-zero counters.
    raw_soft_err = 1'b1; step(); raw_soft_err = 1'b0; steps(4);
    raw_gt_pll_lock = 1'b0; steps(3); raw_gt_pll_lock = 1'b1; steps(20);
    chk("pre_reset_up", link_up, 1'b1);
    resetn = 1'b0; step(); resetn = 1'b1;
    chk("reset_in_up_state", link_state, 2'd0);
    chk("reset_in_up_drop", link_drop_count, 0);
    chk("reset_in_up_status", status_word, 32'd0);
    steps(20);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) raw_channel_up = ~raw_channel_up;
      raw_gt_pll_lock         = ($urandom_range(199) != 0);
      raw_mmcm_not_locked_out = ($urandom_range(299) == 0);
      raw_soft_err            = 1'($urandom_range(1));
      raw_hard_err            = ($urandom_range(99) == 0);
      clear                   = ($urandom_range(49) == 0);
      resetn                  = ($urandom_range(299) != 0);
      if ($urandom_range(15) == 0) raw_lane_up = 4'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qsfp_link_monitor.md
QSFP_LINK_MONITOR -- requirements
Module: qsfp_link_monitor

Interface
REQ-001 SHALL have parameter LANE_COUNT, default 4, number of Aurora lanes per QSFP.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1024, consecutive channel-up cycles required before the link is declared up (minimum 2).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of each event counter.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 raw_channel_up  input  1  Aurora channel_up, asynchronous to clk.
REQ-007 raw_lane_up  input  LANE_COUNT  Aurora lane_up, asynchronous.
REQ-008 raw_gt_pll_lock, raw_hard_err, raw_soft_err, raw_mmcm_not_locked_out  input  1 each  Aurora status, asynchronous.
REQ-009 clear  input  1  single-cycle pulse that clears counters and sticky flags.
REQ-010 link_up  output  1  high only in state UP.
REQ-011 link_state  output  2  current state: 0 DOWN, 1 QUAL, 2 UP.
REQ-012 lane_up, gt_pll_lock, mmcm_not_locked_out  output  LANE_COUNT/1/1  synchronized copies of the raw inputs.
REQ-013 hard_err_sticky  output  1  set by any synchronized hard_err; held until cleared.
REQ-014 soft_err_count  output  CNT_WIDTH  count of soft_err rising edges, saturating.
REQ-015 link_drop_count  output  CNT_WIDTH  count of UP->DOWN transitions, saturating.
REQ-016 status_word  output  32  [LANE_COUNT-1:0] lane_up, [4] link_up, [5] gt_pll_lock, [6] hard_err_sticky, [7] mmcm_not_locked_out, [8] soft_err_count!=0, all other bits 0; feeds the AXI QSFP status register.

Function
REQ-017 Every raw input SHALL pass through a 2-flop synchronizer; logic below uses only the synchronized values (s_*).
REQ-018 A raw level sampled high at edge N SHALL appear on the synchronized output at edge N+1.
REQ-019 Soft-error edge detection SHALL compare s_soft_err with a 1-cycle delayed copy; a rising edge SHALL increment soft_err_count at edge N+2.
REQ-020 A level held high SHALL count once; each new rising edge SHALL count again.
REQ-021 Counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap to 0.
REQ-022 State DOWN SHALL move to QUAL on the edge where s_channel_up=1, loading qual_cnt=1.
REQ-023 In QUAL, qual_cnt SHALL increment every cycle while s_channel_up=1.
REQ-024 In QUAL, s_channel_up=0 SHALL return the FSM to DOWN with qual_cnt=0 and no drop counted.
REQ-025 QUAL SHALL move to UP on the edge where qual_cnt==DEBOUNCE_CYCLES-1 and s_channel_up=1.
REQ-026 Consequence of REQ-022..025: link_up rises DEBOUNCE_CYCLES edges after s_channel_up first reads 1.
REQ-027 In UP, s_channel_up=0 SHALL move the FSM to DOWN on that edge and increment link_drop_count.
REQ-028 In UP, s_mmcm_not_locked_out=1 or s_gt_pll_lock=0 SHALL also move the FSM to DOWN and count a drop, regardless of channel_up.
REQ-029 In DOWN and QUAL, s_mmcm_not_locked_out=1 or s_gt_pll_lock=0 SHALL hold or force the FSM to DOWN.
REQ-030 hard_err_sticky SHALL be set on any cycle with s_hard_err=1.
REQ-031 clear SHALL zero soft_err_count, link_drop_count and hard_err_sticky on the next edge; it SHALL NOT affect FSM state or synchronizers.
REQ-032 Simultaneous clear and counter event: clear wins, and the counter becomes 0.
REQ-033 Simultaneous clear and s_hard_err=1: set wins, and hard_err_sticky stays 1.
REQ-034 status_word SHALL be combinational from registered state and counters, adding no latency.

Reset
REQ-035 While resetn=0 at an edge, all synchronizer flops, the delayed copy, qual_cnt, both counters and hard_err_sticky SHALL become 0, and the FSM SHALL enter DOWN.
REQ-036 Outputs SHALL read 0 one edge after reset is sampled.
REQ-037 Reset mid-QUAL or mid-UP SHALL go straight to DOWN without counting a drop.
REQ-038 After resetn deasserts, qualification SHALL restart from the first synchronized channel_up.

Verification (DEBOUNCE_CYCLES=16, CNT_WIDTH=4)
REQ-039 Raw channel_up, pll_lock=1, mmcm=0, held 20 cycles -> link_state 0->1 at edge 2, link_up=1 at edge 17, link_drop_count=0.
REQ-040 Channel_up high 10 cycles, low 1 cycle, high again -> link_up never asserts before a fresh 16-cycle window completes; no drop counted.
REQ-041 In UP, channel_up drops -> link_up=0 two edges later, link_drop_count=1. In UP, gt_pll_lock drops -> same response.
REQ-042 20 soft_err pulses (1 high, 1 low) -> soft_err_count stops at 15. A 5-cycle soft_err level -> count +1 only.
REQ-043 clear coincident with a soft_err edge -> count=0. Hard_err pulse then clear -> sticky=0. Clear while s_hard_err=1 -> sticky=1.
REQ-044 resetn=0 for 1 cycle while in UP with counters non-zero -> all outputs 0 and state DOWN next edge; drop count stays 0.
